// File: rtl/hsv_core_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// hsv_core_issue_scoreboard : per-register in-flight write counters, RAW/full
// hazard stall and flush sequencing for the issue stage.   Rev 1.0
// ============================================================================
module hsv_core_issue_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 2,
  parameter int TOTAL_W    = 6
) (
  input  logic                  clk_core,
  input  logic                  rst_core_n,
  input  logic                  flush_req,
  output logic                  flush_ack,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic                  rs1_used,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  rd_write,
  input  logic                  issue_fire_i,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  output logic                  hazard,
  output logic [TOTAL_W-1:0]    in_flight,
  output logic                  idle,
  output logic                  err
);

  localparam logic [1:0]       ST_RUN   = 2'd0;
  localparam logic [1:0]       ST_CLEAR = 2'd1;
  localparam logic [1:0]       ST_ACK   = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]                      state_q, state_d;
  logic [NUM_REGS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [TOTAL_W-1:0]              in_flight_q, in_flight_d;
  logic                            err_q, err_d;
  logic                            flush_ack_q, flush_ack_d;

  logic             inc_any, dec_any, same_reg;
  logic             inc_ok, dec_ok, inc_ovf, dec_unf;
  logic [CNT_W-1:0] cnt_rd, cnt_wr;
  logic             run;

  assign run     = (state_q == ST_RUN);
  assign inc_any = issue_fire_i & rd_write & (rd_addr != '0);
  assign dec_any = wr_en & (wr_addr != '0);
  // A write and a writeback to the same register cancel: net count is unchanged.
  assign same_reg = inc_any & dec_any & (rd_addr == wr_addr);
  assign cnt_rd   = cnt_q[rd_addr];
  assign cnt_wr   = cnt_q[wr_addr];
  assign inc_ok   = inc_any & ~same_reg & (cnt_rd != CNT_MAX);
  assign dec_ok   = dec_any & ~same_reg & (cnt_wr != '0);
  assign inc_ovf  = inc_any & ~same_reg & (cnt_rd == CNT_MAX);
  assign dec_unf  = dec_any & ~same_reg & (cnt_wr == '0);

  always_comb begin
    cnt_d = '0;
    if (run) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_d[r] = cnt_q[r];
        if (inc_ok && (rd_addr == REG_ADDR_W'(r))) cnt_d[r] = cnt_q[r] + 1'b1;
        if (dec_ok && (wr_addr == REG_ADDR_W'(r))) cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    in_flight_d = in_flight_q;
    err_d       = err_q;
    case (state_q)
      ST_RUN: begin
        in_flight_d = in_flight_q + {{(TOTAL_W-1){1'b0}}, inc_ok}
                                  - {{(TOTAL_W-1){1'b0}}, dec_ok};
        err_d       = err_q | inc_ovf | dec_unf;
        if (flush_req) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        in_flight_d = '0;
        err_d       = 1'b0;
        state_d     = ST_ACK;
      end
      ST_ACK: begin
        in_flight_d = '0;
        err_d       = 1'b0;
        if (!flush_req) state_d = ST_RUN;
      end
      default: begin
        in_flight_d = '0;
        err_d       = 1'b0;
        state_d     = ST_RUN;
      end
    endcase
    flush_ack_d = (state_d == ST_ACK);
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      in_flight_q <= '0;
      err_q       <= 1'b0;
      flush_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
      flush_ack_q <= flush_ack_d;
    end
  end

  // No writeback bypass: a regfile write lands in the same edge that clears the count.
  assign hazard = ~run
                | valid_i & ( rs1_used & (rs1_addr != '0) & (cnt_q[rs1_addr] != '0)
                            | rs2_used & (rs2_addr != '0) & (cnt_q[rs2_addr] != '0)
                            | rd_write & (rd_addr  != '0) & (cnt_q[rd_addr] == CNT_MAX));

  assign in_flight = in_flight_q;
  assign idle      = (in_flight_q == '0) & run;
  assign err       = err_q;
  assign flush_ack = flush_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_hsv_core_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_hsv_core_issue_scoreboard : scoreboard bench for the issue hazard block.
// Rev 1.0
// ============================================================================
module tb_hsv_core_issue_scoreboard;

  logic       clk_core = 1'b0;
  logic       rst_core_n = 1'b0;
  logic       flush_req = 1'b0;
  logic       flush_ack;
  logic       valid_i = 1'b0;
  logic [4:0] rs1_addr = '0;
  logic       rs1_used = 1'b0;
  logic [4:0] rs2_addr = '0;
  logic       rs2_used = 1'b0;
  logic [4:0] rd_addr = '0;
  logic       rd_write = 1'b0;
  logic       issue_fire_i = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic       hazard;
  logic [5:0] in_flight;
  logic       idle;
  logic       err;

  hsv_core_issue_scoreboard dut (
    .clk_core    (clk_core),
    .rst_core_n  (rst_core_n),
    .flush_req   (flush_req),
    .flush_ack   (flush_ack),
    .valid_i     (valid_i),
    .rs1_addr    (rs1_addr),
    .rs1_used    (rs1_used),
    .rs2_addr    (rs2_addr),
    .rs2_used    (rs2_used),
    .rd_addr     (rd_addr),
    .rd_write    (rd_write),
    .issue_fire_i(issue_fire_i),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .hazard      (hazard),
    .in_flight   (in_flight),
    .idle        (idle),
    .err         (err)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    int hazard;
    int in_flight;
    int idle;
    int err;
    int ack;
  } exp_t;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   bad_cnt   = 0;

  // Reference model: 0 = RUN, 1 = CLEAR, 2 = ACK
  int m_cnt[32];
  int m_state;
  int m_err;

  task automatic check(input string tag, input int obs, input int exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_state = 0;
    m_err   = 0;
  endfunction

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < 32; i++) s += m_cnt[i];
    return s;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    int   h = 0;
    if (valid_i) begin
      if (rs1_used && rs1_addr != 0 && m_cnt[rs1_addr] != 0) h = 1;
      if (rs2_used && rs2_addr != 0 && m_cnt[rs2_addr] != 0) h = 1;
      if (rd_write && rd_addr != 0 && m_cnt[rd_addr] == 3) h = 1;
    end
    if (m_state != 0) h = 1;
    e.hazard    = h;
    e.in_flight = model_sum();
    e.idle      = (model_sum() == 0 && m_state == 0) ? 1 : 0;
    e.err       = m_err;
    e.ack       = (m_state == 2) ? 1 : 0;
    return e;
  endfunction

  function automatic void model_clock();
    bit inc, dec;
    case (m_state)
      0: begin
        inc = issue_fire_i && rd_write && rd_addr != 0;
        dec = wr_en && wr_addr != 0;
        if (!(inc && dec && rd_addr == wr_addr)) begin
          if (inc) begin
            if (m_cnt[rd_addr] == 3) m_err = 1;
            else m_cnt[rd_addr]++;
          end
          if (dec) begin
            if (m_cnt[wr_addr] == 0) m_err = 1;
            else m_cnt[wr_addr]--;
          end
        end
        if (flush_req) m_state = 1;
      end
      1: begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err   = 0;
        m_state = 2;
      end
      default: if (!flush_req) m_state = 0;
    endcase
  endfunction

  // One clock: expectation queued when stimulus is set, compared mid-cycle.
  task automatic step(input string tag);
    exp_t e;
    exp_q.push_back(model_expect());
    @(negedge clk_core);
    e = exp_q.pop_front();
    check({tag, ".hazard"},    int'(hazard),    e.hazard);
    check({tag, ".in_flight"}, int'(in_flight), e.in_flight);
    check({tag, ".idle"},      int'(idle),      e.idle);
    check({tag, ".err"},       int'(err),       e.err);
    check({tag, ".flush_ack"}, int'(flush_ack), e.ack);
    @(posedge clk_core);
    model_clock();
    #1;
  endtask

  task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit rw, input bit fire,
                       input bit we, input int wa, input bit fr);
    valid_i      = v;
    rs1_addr     = 5'(r1);
    rs1_used     = u1;
    rs2_addr     = 5'(r2);
    rs2_used     = u2;
    rd_addr      = 5'(rd);
    rd_write     = rw;
    issue_fire_i = fire;
    wr_en        = we;
    wr_addr      = 5'(wa);
    flush_req    = fr;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".hazard"},    int'(hazard),    0);
    check({tag, ".in_flight"}, int'(in_flight), 0);
    check({tag, ".idle"},      int'(idle),      1);
    check({tag, ".err"},       int'(err),       0);
    check({tag, ".flush_ack"}, int'(flush_ack), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle_in();
    repeat (2) @(posedge clk_core);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_core);
    rst_core_n = 1'b1;
    @(posedge clk_core);
    model_clock();
    #1;

    for (int i = 0; i < 32; i++) begin
      drive(1, i, 1, 31 - i, 1, i, 1, 0, 0, 0, 0);
      step("sweep");
    end

    // RAW on x5 and release by writeback
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);  step("fire5");
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("raw5");
    drive(1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 0);  step("wb5");
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("raw5_clear");

    // saturation on x7
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
      step("fire7");
    end
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);  step("full7");
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);  step("ovf7");
    drive(1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 0);  step("after_ovf7");

    // same-cycle inc/dec on x9
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0);  step("fire9");
    drive(1, 0, 0, 0, 0, 9, 1, 1, 1, 9, 0);  step("incdec9");
    drive(1, 9, 1, 9, 1, 0, 0, 0, 0, 0, 0);  step("hold9");

    // four registers busy, one-cycle flush pulse
    drive(1, 0, 0, 0, 0, 11, 1, 1, 0, 0, 0); step("fire11");
    drive(1, 0, 0, 0, 0, 13, 1, 1, 0, 0, 0); step("fire13");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  step("flush_pulse");
    idle_in();
    for (int k = 0; k < 4; k++) step("flush_drain");

    // x0 never tracked; writeback to an idle register flags err
    drive(1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0);  step("x0_ops");
    drive(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);  step("x0_check");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0); step("unf12");
    idle_in();                               step("unf12_after");

    // held flush, rising together with a fire
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1);  step("flush_fire");
    for (int k = 0; k < 4; k++) begin
      drive(1, 3, 1, 0, 0, 3, 1, 1, 1, 3, 1);
      step("flush_hold");
    end
    idle_in();
    for (int k = 0; k < 3; k++) step("flush_release");

    // reset asserted while in ACK
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 1);  step("pre_rst_flush");
    step("pre_rst_clear");
    idle_in();
    rst_core_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst_mid_flush");
    @(negedge clk_core);
    rst_core_n = 1'b1;
    @(posedge clk_core);
    model_clock();
    #1;

    // random traffic over a small register window
    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 7), ($urandom_range(0, 19) == 0));
      step("rand");
    end

    idle_in();
    for (int k = 0; k < 3; k++) step("final");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
